// File: rtl/shift_ctrl_pkg.sv
// Shared types and constants for the shift_ctrl serial sequencer.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_ctrl_core.sv
// Bidirectional parallel-load shift register: load wins over shift, and
// ser_in fills the end vacated by the shift.
module shift_ctrl_core
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             dir,
    input  logic             ser_in,
    output logic [WIDTH-1:0] data,
    output logic             out_bit
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        // NOTE: default first so every path assigns data_d; no latch is inferred.
        data_d = data_q;
        if (load) begin
            data_d = load_data;
        end else if (shift_en) begin
            data_d = (dir == DIR_LEFT) ? {data_q[WIDTH-2:0], ser_in}
                                       : {ser_in, data_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking so every flop samples pre-edge values.
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data    = data_q;
    assign out_bit = (dir == DIR_LEFT) ? data_q[WIDTH-1] : data_q[0];

endmodule

// File: rtl/shift_ctrl.sv
// Command/response sequencer: loads a word, shifts it out one bit per
// un-held cycle while capturing ser_in, then presents the captured word.
module shift_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic             ser_hold,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             load;
    logic             shift_en;
    logic             out_bit;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        load     = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    load    = 1'b1;
                    dir_d   = cmd_dir;
                    cnt_d   = (cmd_len == '0) ? FULL_LEN : cmd_len;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // A held final shift simply waits; completion needs a real shift.
                if (!ser_hold) begin
                    shift_en = 1'b1;
                    cnt_d    = cnt_q - ONE;
                    if (cnt_q == ONE) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= DIR_LEFT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    shift_ctrl_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (cmd_data),
        .shift_en  (shift_en),
        .dir       (dir_q),
        .ser_in    (ser_in),
        .data      (rsp_data),
        .out_bit   (out_bit)
    );

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == DONE);
    assign ser_valid = shift_en;
    assign ser_out   = (state_q == SHIFT) && out_bit;

endmodule

// File: tb/tb_shift_ctrl.sv
// Scoreboard bench for shift_ctrl: driver queues expected serial bits and
// responses from an arithmetic model; a monitor pops and compares them.
module tb_shift_ctrl;

    localparam int W = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [W-1:0]  cmd_data = '0;
    logic          cmd_dir = 1'b0;
    logic [CW-1:0] cmd_len = '0;
    logic          ser_hold = 1'b0;
    logic          ser_in = 1'b0;
    logic          ser_out;
    logic          ser_valid;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [W-1:0]  rsp_data;
    logic          busy;

    int n_vec = 0;
    int n_err = 0;

    bit           exp_bits[$];
    logic [W-1:0] exp_rsp[$];

    shift_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_dir   (cmd_dir),
        .cmd_len   (cmd_len),
        .ser_hold  (ser_hold),
        .ser_in    (ser_in),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word after L shifts: in_bits[i] is the i-th bit shifted in.
    function automatic logic [W-1:0] model_rsp(input logic [W-1:0] data, input logic dir,
                                               input int len, input logic [W-1:0] in_bits);
        int unsigned acc;
        if (dir == 1'b0) begin
            acc = (int'(data) << len) & ((1 << W) - 1);
            for (int i = 0; i < len; i++) acc = acc | (int'(in_bits[i]) << (len - 1 - i));
        end else begin
            acc = int'(data) >> len;
            for (int i = 0; i < len; i++) acc = acc | (int'(in_bits[i]) << (W - len + i));
        end
        return acc[W-1:0];
    endfunction

    // Bit emitted on the i-th shift: MSB-first for left, LSB-first for right.
    function automatic bit model_bit(input logic [W-1:0] data, input logic dir, input int i);
        int unsigned pos;
        pos = (dir == 1'b0) ? (W - 1 - i) : i;
        return ((int'(data) >> pos) & 1) != 0;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (ser_valid) begin
                if (exp_bits.size() == 0) begin
                    check("spurious_shift", 32'(ser_valid), 32'd0);
                end else begin
                    check("ser_out", 32'(ser_out), 32'(exp_bits.pop_front()));
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_rsp.size() == 0) begin
                    check("spurious_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    check("rsp_data", 32'(rsp_data), 32'(exp_rsp.pop_front()));
                end
            end
        end
    end

    task automatic run_cmd(input logic [W-1:0] data, input logic dir, input logic [CW-1:0] len,
                           input logic [W-1:0] in_bits, input logic [31:0] hold_mask,
                           input int bp, input bit keep_valid);
        int L;
        int shifts;
        int cyc;
        logic [W-1:0] exp_word;
        L = (len == 0) ? W : int'(len);
        shifts = 0;
        cyc = 0;
        exp_word = model_rsp(data, dir, L, in_bits);
        @(negedge clk);
        check("idle_ready", 32'(cmd_ready), 32'd1);
        check("idle_quiet", 32'({busy, rsp_valid, ser_valid, ser_out}), 32'd0);
        for (int i = 0; i < L; i++) exp_bits.push_back(model_bit(data, dir, i));
        exp_rsp.push_back(exp_word);
        cmd_valid = 1'b1;
        cmd_data  = data;
        cmd_dir   = dir;
        cmd_len   = len;
        @(posedge clk);
        #1;
        if (keep_valid) cmd_data = ~data;
        else            cmd_valid = 1'b0;
        while (shifts < L && cyc < 64) begin
            ser_hold = (cyc < 32) ? hold_mask[cyc] : 1'b0;
            ser_in   = ser_hold ? 1'($urandom_range(1, 0)) : in_bits[shifts];
            @(negedge clk);
            check("shift_valid", 32'(ser_valid), 32'(!ser_hold));
            check("shift_status", 32'({cmd_ready, rsp_valid, busy}), 32'b001);
            @(posedge clk);
            #1;
            if (!ser_hold) shifts++;
            cyc++;
        end
        if (shifts < L) check("shift_timeout", 32'(shifts), 32'(L));
        ser_hold = 1'b0;
        ser_in   = 1'($urandom_range(1, 0));
        for (int b = 0; b < bp; b++) begin
            rsp_ready = 1'b0;
            @(negedge clk);
            check("bp_status", 32'({cmd_ready, rsp_valid, busy, ser_valid, ser_out}), 32'b01100);
            check("bp_data", 32'(rsp_data), 32'(exp_word));
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("done_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #3;
        check("reset_outputs", 32'({cmd_ready, busy, rsp_valid, ser_valid, ser_out}), 32'b10000);
        check("reset_data", 32'(rsp_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases from the test plan.
        run_cmd(8'hC1, 1'b0, 4'd8, 8'h00, 32'h0, 0, 1'b0);
        run_cmd(8'hC1, 1'b1, 4'd0, 8'hFF, 32'h0, 0, 1'b0);
        run_cmd(8'hC1, 1'b0, 4'd3, 8'hFF, 32'h0, 0, 1'b0);
        run_cmd(8'hC1, 1'b0, 4'd8, 8'h00, 32'h0000_000C, 0, 1'b0);
        run_cmd(8'hC1, 1'b0, 4'd3, 8'hFF, 32'h0000_0004, 0, 1'b0);
        run_cmd(8'h5A, 1'b1, 4'd8, 8'h3C, 32'h0, 3, 1'b1);
        run_cmd(8'hA5, 1'b0, 4'd1, 8'h01, 32'h0, 0, 1'b0);

        // Abort mid-transfer: after the 4th shift, reset must clear everything at once.
        @(negedge clk);
        for (int i = 0; i < W; i++) exp_bits.push_back(model_bit(8'hC1, 1'b0, i));
        cmd_valid = 1'b1;
        cmd_data  = 8'hC1;
        cmd_dir   = 1'b0;
        cmd_len   = 4'd8;
        ser_in    = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_outputs", 32'({cmd_ready, busy, rsp_valid, ser_valid, ser_out}), 32'b10000);
        check("abort_data", 32'(rsp_data), 32'd0);
        check("abort_shifted", 32'(exp_bits.size()), 32'(W - 4));
        exp_bits.delete();
        @(negedge clk);
        rst = 1'b0;
        run_cmd(8'hC1, 1'b0, 4'd8, 8'h00, 32'h0, 0, 1'b0);

        // Randomized traffic, including holds on any cycle and response backpressure.
        for (int n = 0; n < 40; n++) begin
            run_cmd(8'($urandom()), 1'($urandom_range(1, 0)), 4'($urandom_range(8, 0)),
                    8'($urandom()), $urandom() & $urandom(), $urandom_range(3, 0),
                    1'($urandom_range(1, 0)));
        end

        @(negedge clk);
        check("sb_drain", 32'(exp_bits.size() + exp_rsp.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
